// File: rtl/ssd_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with double-buffered digit data.
// Outputs are registered one clock behind the scan counters; new data is swapped in only at frame wrap.
module ssd_scan_driver #(
  parameter int TICK_BITS = 18,
  parameter int BLANK     = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Data,
  input  logic [7:0]  Dp_in,
  input  logic [7:0]  Digit_en,
  input  logic        Load,
  output logic        Load_ack,
  output logic [7:0]  An,
  output logic [7:0]  Cath,
  output logic        Frame_done
);

  localparam logic [TICK_BITS-1:0] BLANK_W = TICK_BITS'(BLANK);

  logic [TICK_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [31:0]          stg_data_q, stg_data_d, sh_data_q, sh_data_d;
  logic [7:0]           stg_dp_q, stg_dp_d, sh_dp_q, sh_dp_d;
  logic [7:0]           stg_en_q, stg_en_d, sh_en_q, sh_en_d;
  logic                 pend_q, pend_d;
  logic [7:0]           an_q, an_d, cath_q, cath_d;
  logic                 ack_q, ack_d, fdone_q, fdone_d;
  logic                 tick, bnd, lit;
  logic [3:0]           nib;

  // Active-low abcdefg glyphs for hex digits.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = &cnt_q;
    bnd   = tick && (idx_q == 3'd7);
    cnt_d = cnt_q + TICK_BITS'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;

    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    stg_en_d   = stg_en_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    fdone_d    = bnd;

    // Shadow takes the pre-edge staging, so a coincident Load stays pending for the next frame.
    if (bnd && pend_q) begin
      sh_data_d = stg_data_q;
      sh_dp_d   = stg_dp_q;
      sh_en_d   = stg_en_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end
    if (Load) begin
      stg_data_d = Data;
      stg_dp_d   = Dp_in;
      stg_en_d   = Digit_en;
      pend_d     = 1'b1;
    end

    lit    = sh_en_q[idx_q] && (cnt_q >= BLANK_W);
    nib    = sh_data_q[{idx_q, 2'b00} +: 4];
    an_d   = 8'hFF;
    cath_d = 8'hFF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      cath_d      = {seg7(nib), ~sh_dp_q[idx_q]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      stg_data_q <= '0;
      stg_dp_q   <= '0;
      stg_en_q   <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      pend_q     <= 1'b0;
      an_q       <= 8'hFF;
      cath_q     <= 8'hFF;
      ack_q      <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stg_data_q <= stg_data_d;
      stg_dp_q   <= stg_dp_d;
      stg_en_q   <= stg_en_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
      ack_q      <= ack_d;
      fdone_q    <= fdone_d;
    end
  end

  assign An         = an_q;
  assign Cath       = cath_q;
  assign Load_ack   = ack_q;
  assign Frame_done = fdone_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver with TICK_BITS=4, BLANK=2 (16-clock digits, 128-clock frames).
// The reference tracks elapsed clocks since reset and derives the scan position arithmetically.
module tb_ssd_scan_driver;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Data;
  logic [7:0]  Dp_in;
  logic [7:0]  Digit_en;
  logic        Load;
  logic        Load_ack;
  logic [7:0]  An;
  logic [7:0]  Cath;
  logic        Frame_done;

  ssd_scan_driver #(.TICK_BITS(4), .BLANK(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Data(Data), .Dp_in(Dp_in), .Digit_en(Digit_en),
    .Load(Load), .Load_ack(Load_ack), .An(An), .Cath(Cath), .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  localparam logic [6:0] GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int tests = 0;
  int fails = 0;
  int acks  = 0;
  int t     = 0;
  logic [31:0] st_data, sh_data;
  logic [7:0]  st_dp, sh_dp, st_en, sh_en;
  logic        m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    st_data = '0; st_dp = '0; st_en = '0;
    sh_data = '0; sh_dp = '0; sh_en = '0;
    m_pend = 1'b0;
  endtask

  // One clock: drive inputs, let the edge pass, then compare against the reference.
  task automatic cyc(input logic ld, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    int c, ix;
    logic [7:0] ea, ec;
    logic bnd, eack;
    Load = ld; Data = d; Dp_in = dp; Digit_en = en;
    @(posedge Clk); #1;
    c   = t % 16;
    ix  = (t / 16) % 8;
    bnd = (t % 128) == 127;
    ea  = 8'hFF;
    ec  = 8'hFF;
    if (sh_en[ix] && c >= 2) begin
      ea[ix] = 1'b0;
      ec     = {GLYPH[sh_data[ix*4 +: 4]], ~sh_dp[ix]};
    end
    eack = bnd && m_pend;
    if (bnd && m_pend) begin
      sh_data = st_data; sh_dp = st_dp; sh_en = st_en;
      m_pend  = 1'b0;
    end
    if (ld) begin
      st_data = d; st_dp = dp; st_en = en;
      m_pend  = 1'b1;
    end
    t++;
    chk("an", An, ea);
    chk("cath", Cath, ec);
    chk("load_ack", Load_ack, eack);
    chk("frame_done", Frame_done, bnd);
    chk("an_onehot", ($countones(~An) <= 1), 1);
    if (Load_ack) acks++;
    Load = 1'b0;
  endtask

  task automatic run_to(input int p);
    int n = 0;
    while ((t % 128) != p && n < 300) begin
      cyc(1'b0, Data, Dp_in, Digit_en);
      n++;
    end
    chk("run_to", t % 128, p);
  endtask

  initial begin
    int a0, n, ix;
    Reset_n = 1'b0; Load = 1'b1; Data = 32'hDEADBEEF; Dp_in = 8'hFF; Digit_en = 8'hFF;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_an", An, 8'hFF);
    chk("rst_cath", Cath, 8'hFF);
    chk("rst_ack", Load_ack, 1'b0);
    chk("rst_fdone", Frame_done, 1'b0);
    Reset_n = 1'b1; Load = 1'b0;
    repeat (3) cyc(1'b0, 32'h0, 8'h0, 8'h0);
    chk("rst_load_discarded", An, 8'hFF);

    // Basic display
    cyc(1'b1, 32'h76543210, 8'h01, 8'hFF);
    a0 = acks;
    run_to(0);
    chk("basic_ack", Load_ack, 1'b1);
    run_to(1);   chk("blank0_an", An, 8'hFF);
    run_to(2);   chk("blank1_an", An, 8'hFF);
    run_to(3);   chk("d0_an", An, 8'hFE);  chk("d0_cath", Cath, 8'h02);
    run_to(19);  chk("d1_an", An, 8'hFD);  chk("d1_cath", Cath, 8'h9F);
    run_to(115); chk("d7_an", An, 8'h7F);  chk("d7_cath", Cath, 8'h1F);
    run_to(0);
    chk("idle_no_ack", Load_ack, 1'b0);
    chk("idle_fdone", Frame_done, 1'b1);
    chk("basic_ack_count", acks - a0, 1);

    // Asynchronous reset while digit 2 is lit
    run_to(40);
    chk("pre_rst_an", An, 8'hFB);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_an", An, 8'hFF);
    chk("async_cath", Cath, 8'hFF);
    chk("async_ack", Load_ack, 1'b0);
    Load = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1; Load = 1'b0;
    model_reset();
    n = 0;
    while (n < 200) begin
      cyc(1'b0, 32'h0, 8'h0, 8'h0);
      n++;
      if (Frame_done) break;
    end
    chk("first_fdone_clocks", n, 128);

    // Digit enable on low four digits only
    cyc(1'b1, 32'h89ABCDEF, 8'hAA, 8'h0F);
    run_to(0);
    chk("en_ack", Load_ack, 1'b1);
    repeat (128) begin
      cyc(1'b0, Data, Dp_in, Digit_en);
      ix = ((t - 1) % 128) / 16;
      chk("en_an_hi", An[7:4], 4'hF);
      if (ix >= 4) chk("en_cath_dark", Cath, 8'hFF);
    end

    // Several loads within one frame
    run_to(5);
    cyc(1'b1, 32'h11111111, 8'h00, 8'hFF);
    cyc(1'b0, Data, Dp_in, Digit_en);
    cyc(1'b1, 32'h22222222, 8'h00, 8'hFF);
    a0 = acks;
    run_to(0);
    run_to(127);
    chk("multi_ack_count", acks - a0, 1);
    run_to(83);
    chk("multi_an", An, 8'hDF);
    chk("multi_cath", Cath, 8'h25);

    // Load coincident with the boundary while pending
    run_to(10);
    cyc(1'b1, 32'h0123ABCD, 8'h00, 8'hFF);
    run_to(127);
    cyc(1'b1, 32'hFEDCBA98, 8'hFF, 8'hFF);
    chk("bnd_ack_old", Load_ack, 1'b1);
    chk("bnd_fdone", Frame_done, 1'b1);
    run_to(3);
    chk("bnd_old_cath", Cath, 8'h85);
    a0 = acks;
    run_to(0);
    chk("bnd_ack_new", Load_ack, 1'b1);
    chk("bnd_ack_count", acks - a0, 1);
    run_to(3);
    chk("bnd_new_an", An, 8'hFE);
    chk("bnd_new_cath", Cath, 8'h00);

    // Randomized traffic against the reference
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0)
        cyc(1'b1, $urandom, 8'($urandom), 8'($urandom));
      else
        cyc(1'b0, $urandom, 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter TICK_BITS, default 18, meaning each digit period lasts 2^TICK_BITS clocks (2.62 ms at 100 MHz).
REQ-002 SHALL have parameter BLANK, default 16, meaning anode-off clocks at the start of each digit period; legal range 0 <= BLANK < 2^TICK_BITS.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Data, input, 32 bits: eight hex nibbles; digit k is Data[4k+3:4k].
REQ-006 SHALL have port Dp_in, input, 8 bits: decimal point per digit; 1 = lit.
REQ-007 SHALL have port Digit_en, input, 8 bits: per-digit enable; 0 = digit dark.
REQ-008 SHALL have port Load, input, 1 bit: sampled each clock; 1 = capture Data/Dp_in/Digit_en.
REQ-009 SHALL have port Load_ack, output, 1 bit: one-clock pulse when captured values become visible.
REQ-010 SHALL have port An, output, 8 bits: active-low anodes; An[k] drives digit k.
REQ-011 SHALL have port Cath, output, 8 bits: active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, MSB = Ca.
REQ-012 SHALL have port Frame_done, output, 1 bit: one-clock pulse at each 7->0 digit wrap.

Function
REQ-013 SHALL count prescaler cnt (TICK_BITS wide) 0..2^TICK_BITS-1, wrapping to 0; tick = (cnt == all ones).
REQ-014 SHALL hold 3-bit digit index idx, incremented mod 8 on tick; boundary = tick with idx == 7.
REQ-015 SHALL keep a staging register set (data/dp/en) plus a pending flag, and a shadow register set that drives the display.
REQ-016 SHALL, on Load = 1, overwrite staging with the current inputs and set pending; this applies regardless of pending state.
REQ-017 SHALL, at boundary with pending = 1, copy staging (pre-edge contents) to shadow, clear pending and pulse Load_ack in the following clock.
REQ-018 SHALL, when Load and a boundary coincide, transfer the old staging (acked if pending was set), capture the new inputs into staging and leave pending = 1.
REQ-019 SHALL issue exactly one Load_ack per boundary transfer, however many Loads preceded it; no Load_ack at a boundary with pending = 0.
REQ-020 SHALL pulse Frame_done in the clock following each boundary, coincident with any Load_ack.
REQ-021 SHALL register An each clock: bit idx = 0 only if shadow_en[idx] = 1 and cnt >= BLANK; all other bits = 1. Latency is one clock from cnt/idx.
REQ-022 SHALL register Cath each clock: segments from the decode of shadow nibble idx, Dp = ~shadow_dp[idx]. Same one-clock latency as An.
REQ-023 SHALL drive Cath = 8'hFF whenever the An bit for the current digit would be 1 (disabled digit or blanking window).
REQ-024 SHALL decode abcdefg (active-low) with standard glyphs 0-9, A, b, C, d, E, F. Examples: 0 = 0000001, 1 = 1001111, 2 = 0010010, 8 = 0000000, A = 0001000, F = 0111000.
REQ-025 SHALL never assert more than one An bit low in any clock.

Reset
REQ-026 SHALL, while Reset_n = 0, immediately and asynchronously force all state to its reset value:
- cnt = 0, idx = 0
- staging and shadow = 0 (all digits disabled), pending = 0
- An = 8'hFF, Cath = 8'hFF
- Load_ack = 0, Frame_done = 0
REQ-027 SHALL, after Reset_n rises, start at digit 0 with cnt = 0; Loads presented during reset are discarded.

Verification (TICK_BITS = 4, BLANK = 2)
REQ-028 Reset: drop Reset_n mid-period while a digit is lit -> An = FF and Cath = FF without waiting for a clock edge. After release, Frame_done first pulses 128 clocks later.
REQ-029 Basic display: Load once with Data = 32'h76543210, Digit_en = FF, Dp_in = 01 -> one Load_ack at the next boundary, then:
- digit 0: An = FE, Cath = 8'h02
- digit 1: An = FD, Cath = 8'h9F
- digit 7: An = 7F, Cath = 8'h1F
REQ-030 Digit enable: Load Digit_en = 0F -> An[7:4] stay 1 and Cath = FF throughout digit periods 4-7.
REQ-031 Multiple loads: Load 32'h11111111, then 32'h22222222 in the same frame -> single Load_ack; all digits show glyph 2 (Cath = 8'h25).
REQ-032 Load at boundary: with pending = 1, assert Load coincident with a boundary -> Load_ack for the old values; new values appear, with a second Load_ack, exactly one frame (128 clocks) later.
REQ-033 Blanking: in every digit period An = FF for clocks cnt = 0..1 (observed one clock later), and never two An bits low simultaneously.
